impartitor_secv: RTL and testbench



---
 rtl/impartitor_pkg.sv | 19 +
 rtl/impartitor_pas.sv | 22 ++
 rtl/impartitor_secv.sv | 146 ++++++++++++++
 tb/tb_impartitor_secv.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/impartitor_pkg.sv
// Shared types and constants for the impartitor_secv sequential restoring divider.
package impartitor_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must be able to hold the value width.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/impartitor_pas.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module impartitor_pas #(
  parameter int W = 8
) (
  input  logic [W:0]   r_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   r_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  always_comb begin
    shifted = {r_in, bit_in};
    trial   = shifted - {2'b00, divisor};
    q_bit   = (shifted >= {2'b00, divisor});
    r_out   = q_bit ? trial[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/impartitor_secv.sv
// Sequential restoring divider: 2*width-bit dividend / width-bit divisor, one quotient bit per clock.
// Define DIV_OVF_CHECK_EN to flag overflow / divide-by-zero at load and finish in one cycle.
module impartitor_secv
  import impartitor_pkg::*;
#(
  parameter int width = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [2*width-1:0] OpA,
  input  logic [width-1:0]   OpB,
  output logic [width-1:0]   quot,
  output logic [width-1:0]   rem,
  output logic               busy,
  output logic               ready,
  output logic               ovf
);

  localparam int CW = cnt_width(width);

  state_e           state_q, state_d;
  logic [width:0]   r_q, r_d;
  logic [width-1:0] lo_q, lo_d;
  logic [width-1:0] dvs_q, dvs_d;
  logic [width-1:0] quot_q, quot_d;
  logic [width-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
`ifdef DIV_OVF_CHECK_EN
  logic             ovf_q, ovf_d;
  logic             ovf_hit;
`endif

  logic [width:0]   r_step;
  logic             q_bit;

  // lo_q shifts dividend bits out of its MSB while quotient bits enter at its LSB.
  impartitor_pas #(.W(width)) u_pas (
    .r_in    (r_q),
    .bit_in  (lo_q[width-1]),
    .divisor (dvs_q),
    .r_out   (r_step),
    .q_bit   (q_bit)
  );

`ifdef DIV_OVF_CHECK_EN
  assign ovf_hit = (OpB == '0) || (OpA[2*width-1:width] >= OpB);
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case leaves a latch.
    state_d = state_q;
    r_d     = r_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
`ifdef DIV_OVF_CHECK_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (load) begin
          dvs_d   = OpB;
          r_d     = {1'b0, OpA[2*width-1:width]};
          lo_d    = OpA[width-1:0];
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef DIV_OVF_CHECK_EN
          ovf_d   = 1'b0;
          if (ovf_hit) begin
            state_d = DONE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            ovf_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
          end
`endif
        end
      end
      RUN: begin
        r_d   = r_step;
        lo_d  = {lo_q[width-2:0], q_bit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(width - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          quot_d  = {lo_q[width-2:0], q_bit};
          rem_d   = r_step[width-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef DIV_OVF_CHECK_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q <= state_d;
      r_q     <= r_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef DIV_OVF_CHECK_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign quot  = quot_q;
  assign rem   = rem_q;
  assign busy  = busy_q;
  assign ready = ready_q;
`ifdef DIV_OVF_CHECK_EN
  assign ovf   = ovf_q;
`else
  assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_impartitor_secv.sv
// Directed self-checking bench for impartitor_secv (width = 8), hand-computed expectations.
module tb_impartitor_secv;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] OpA;
  logic [7:0]  OpB;
  logic [7:0]  quot;
  logic [7:0]  rem;
  logic        busy;
  logic        ready;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  impartitor_secv #(.width(8)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .OpA   (OpA),
    .OpB   (OpB),
    .quot  (quot),
    .rem   (rem),
    .busy  (busy),
    .ready (ready),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; loads at the next posedge and waits for ready.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic eo,
                         input int lat, input bit mid_load);
    int n;
    int bc;
    load = 1'b1;
    OpA  = a;
    OpB  = b;
    @(negedge clk);
    load = 1'b0;
    n    = 1;
    bc   = 0;
    check({tag, "_busy_c1"}, busy, (lat > 1));
    check({tag, "_ready_c1"}, ready, (lat == 1));
    while (!ready && n < 40) begin
      if (busy) bc++;
      if (mid_load && n == 3) begin
        load = 1'b1;
        OpA  = 16'd50;
        OpB  = 8'd3;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, bc, lat - 1);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    OpA   = '0;
    OpB   = '0;
    repeat (3) @(negedge clk);
    check("rst_quot", quot, 8'h00);
    check("rst_rem", rem, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", ready, 1'b0);

    // Consecutive calls exercise back-to-back loads in the first DONE cycle.
    run_div("d1000_7", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 9, 1'b0);
    run_div("dFEFF_FF", 16'hFEFF, 8'hFF, 8'd255, 8'd254, 1'b0, 9, 1'b0);
    run_div("d0_5", 16'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9, 1'b0);
    run_div("d7FFF_80", 16'h7FFF, 8'h80, 8'd255, 8'd127, 1'b0, 9, 1'b0);
    run_div("d50_3", 16'd50, 8'd3, 8'd16, 8'd2, 1'b0, 9, 1'b0);

`ifdef DIV_OVF_CHECK_EN
    run_div("ovf_FFFE_FF", 16'hFFFE, 8'hFF, 8'hFF, 8'h00, 1'b1, 1, 1'b0);
    run_div("ovf_div0", 16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1, 1'b0);
`else
    run_div("div0_1234", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b0, 9, 1'b0);
`endif

    run_div("ignored_load", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 9, 1'b1);

    // Abort mid-run with asynchronous reset.
    @(negedge clk);
    load = 1'b1;
    OpA  = 16'hFEFF;
    OpB  = 8'hFF;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_quot", quot, 8'h00);
    check("mid_rst_rem", rem, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", busy, 1'b0);
    check("post_rst_idle_ready", ready, 1'b0);

    run_div("post_rst", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
